// File: rtl/intersection_pkg.sv
// Shared types and default timing for the intersection scheduler.
// Phase encoding is also the value driven on the debug phase port.
package intersection_pkg;

   typedef enum logic [2:0] {
      NS_GRN = 3'd0,
      NS_YEL = 3'd1,
      CLR_A  = 3'd2,
      EW_GRN = 3'd3,
      EW_YEL = 3'd4,
      CLR_B  = 3'd5,
      WALK   = 3'd6
   } phase_t;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } dir_t;

   localparam int DEF_MIN_GREEN = 8;
   localparam int DEF_MAX_GREEN = 20;
   localparam int DEF_YELLOW_T  = 3;
   localparam int DEF_CLEAR_T   = 2;
   localparam int DEF_WALK_T    = 6;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Per-phase tick counter: cleared on every phase entry, advanced only on tick,
// and flags the tick cycle on which a phase of length `limit` runs out.
module phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       tick,
   input  logic [7:0] limit,
   output logic [7:0] count,
   output logic       expired
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (tick && (count_q != 8'hFF)) begin
         count_d = count_q + 8'd1;
      end
   end

   // NOTE: state updates use <= so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign expired = tick && (count_q == (limit - 8'd1));

endmodule

// File: rtl/intersection_scheduler.sv
// Two-way intersection controller with all-red clearance and an on-demand
// pedestrian walk phase inserted after either clearance.
module intersection_scheduler
   import intersection_pkg::*;
#(
   parameter int MIN_GREEN = DEF_MIN_GREEN,
   parameter int MAX_GREEN = DEF_MAX_GREEN,
   parameter int YELLOW_T  = DEF_YELLOW_T,
   parameter int CLEAR_T   = DEF_CLEAR_T,
   parameter int WALK_T    = DEF_WALK_T
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       ped_req,
   input  logic       ns_car,
   input  logic       ew_car,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   if (MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN || MAX_GREEN > 255 ||
       YELLOW_T < 1 || YELLOW_T > 255 || CLEAR_T < 1 || CLEAR_T > 255 ||
       WALK_T < 1 || WALK_T > 255) begin : g_bad_params
      $error("intersection_scheduler: illegal duration parameters");
   end

   localparam logic [7:0] MIN_M1  = 8'(MIN_GREEN - 1);
   localparam logic [7:0] MAX_L   = 8'(MAX_GREEN);
   localparam logic [7:0] YEL_L   = 8'(YELLOW_T);
   localparam logic [7:0] CLR_L   = 8'(CLEAR_T);
   localparam logic [7:0] WALK_L  = 8'(WALK_T);

   phase_t     state_q, state_d;
   dir_t       next_dir_q, next_dir_d;
   logic       ped_pending_q, ped_pending_d;
   logic       ped_ack_q, ped_ack_d;

   logic [7:0] limit;
   logic [7:0] count;
   logic       expired;
   logic       clear;
   logic       min_reached;
   logic       enter_walk;

   phase_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .tick    (tick),
      .limit   (limit),
      .count   (count),
      .expired (expired)
   );

   always_comb begin
      limit = CLR_L;
      case (state_q)
         NS_GRN, EW_GRN: limit = MAX_L;
         NS_YEL, EW_YEL: limit = YEL_L;
         WALK:           limit = WALK_L;
         default:        limit = CLR_L;
      endcase
   end

   // Early green release needs at least MIN_GREEN ticks already served.
   assign min_reached = (count >= MIN_M1);

   always_comb begin
      state_d    = state_q;
      next_dir_d = next_dir_q;
      case (state_q)
         NS_GRN: begin
            if (expired || (tick && min_reached && (ew_car || ped_pending_q))) begin
               state_d = NS_YEL;
            end
         end
         NS_YEL: if (expired) state_d = CLR_A;
         CLR_A: begin
            if (expired) begin
               state_d    = ped_pending_q ? WALK : EW_GRN;
               next_dir_d = DIR_EW;
            end
         end
         EW_GRN: begin
            if (expired || (tick && min_reached && (ns_car || ped_pending_q))) begin
               state_d = EW_YEL;
            end
         end
         EW_YEL: if (expired) state_d = CLR_B;
         CLR_B: begin
            if (expired) begin
               state_d    = ped_pending_q ? WALK : NS_GRN;
               next_dir_d = DIR_NS;
            end
         end
         WALK: begin
            if (expired) begin
               state_d = (next_dir_q == DIR_EW) ? EW_GRN : NS_GRN;
            end
         end
         default: state_d = CLR_B;
      endcase
   end

   assign clear      = (state_d != state_q);
   assign enter_walk = (state_d == WALK) && (state_q != WALK);

   // A request on the entering-WALK edge is served by that walk, so the clear wins.
   always_comb begin
      ped_pending_d = ped_pending_q;
      if (enter_walk) begin
         ped_pending_d = 1'b0;
      end else if (ped_req && (state_q != WALK)) begin
         ped_pending_d = 1'b1;
      end
      ped_ack_d = enter_walk;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= CLR_B;
         next_dir_q    <= DIR_NS;
         ped_pending_q <= 1'b0;
         ped_ack_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         next_dir_q    <= next_dir_d;
         ped_pending_q <= ped_pending_d;
         ped_ack_q     <= ped_ack_d;
      end
   end

   always_comb begin
      ns_red    = 1'b0;
      ns_yellow = 1'b0;
      ns_green  = 1'b0;
      ew_red    = 1'b0;
      ew_yellow = 1'b0;
      ew_green  = 1'b0;
      walk      = 1'b0;
      case (state_q)
         NS_GRN: begin ns_green  = 1'b1; ew_red = 1'b1; end
         NS_YEL: begin ns_yellow = 1'b1; ew_red = 1'b1; end
         EW_GRN: begin ew_green  = 1'b1; ns_red = 1'b1; end
         EW_YEL: begin ew_yellow = 1'b1; ns_red = 1'b1; end
         WALK:   begin ns_red = 1'b1; ew_red = 1'b1; walk = 1'b1; end
         default: begin ns_red = 1'b1; ew_red = 1'b1; end
      endcase
   end

   assign ped_ack = ped_ack_q;
   assign phase   = state_q;

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-002 Parameter MIN_GREEN, default 8, SHALL set the minimum green duration in ticks.
REQ-003 Parameter MAX_GREEN, default 20, SHALL set the maximum green duration in ticks.
REQ-004 Parameter YELLOW_T, default 3, SHALL set the yellow duration in ticks.
REQ-005 Parameter CLEAR_T, default 2, SHALL set the all-red clearance duration in ticks.
REQ-006 Parameter WALK_T, default 6, SHALL set the pedestrian walk duration in ticks.
REQ-007 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-008 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-009 Port tick, input, 1 bit, SHALL be a single-cycle time-base strobe.
REQ-010 Port ped_req, input, 1 bit, SHALL be a pedestrian button pulse or level.
REQ-011 Ports ns_car and ew_car, inputs, 1 bit each, SHALL be the vehicle-present sensors.
REQ-012 Ports ns_red, ns_yellow and ns_green, outputs, 1 bit each, SHALL drive the north-south lamps.
REQ-013 Ports ew_red, ew_yellow and ew_green, outputs, 1 bit each, SHALL drive the east-west lamps.
REQ-014 Port walk, output, 1 bit, SHALL drive the pedestrian walk signal.
REQ-015 Port ped_ack, output, 1 bit, SHALL pulse for one cycle when a pedestrian request is served.
REQ-016 Port phase, output, 3 bits, SHALL carry the current state encoding for debug.

Function
REQ-017 States SHALL be NS_GRN, NS_YEL, CLR_A, EW_GRN, EW_YEL, CLR_B and WALK.
REQ-018 All outputs except ped_ack SHALL be decoded only from the state register, with no input-to-output combinational path.
REQ-019 Outputs SHALL be: NS_GRN = ns_green+ew_red; NS_YEL = ns_yellow+ew_red; EW_GRN = ew_green+ns_red; EW_YEL = ew_yellow+ns_red; CLR_A/CLR_B = both red; WALK = both red+walk.
REQ-020 Exactly one lamp per direction SHALL be lit every cycle, and the two greens SHALL never be lit together.
REQ-021 An 8-bit tick counter SHALL clear to 0 on every state entry and SHALL increment only on cycles with tick=1.
REQ-022 A state of duration N SHALL exit on the clock edge of the cycle in which tick=1 and the counter equals N-1, so each state lasts exactly N ticks.
REQ-023 In NS_GRN, the block SHALL exit to NS_YEL at the MAX_GREEN expiry, or earlier once the counter is at or past MIN_GREEN-1 on a tick cycle with ew_car=1 or ped_pending=1.
REQ-024 EW_GRN SHALL follow the same rule as NS_GRN, using ns_car, and SHALL exit to EW_YEL.
REQ-025 A green state SHALL hold until MAX_GREEN when no cross-street car and no pending request are present.
REQ-026 The state sequence SHALL be: NS_YEL→CLR_A after YELLOW_T; EW_YEL→CLR_B after YELLOW_T.
REQ-027 At CLR_A expiry (CLEAR_T), the block SHALL go to WALK if ped_pending, else to EW_GRN.
REQ-028 At CLR_B expiry (CLEAR_T), the block SHALL go to WALK if ped_pending, else to NS_GRN.
REQ-029 A next_dir register SHALL be set to EW on leaving CLR_A and to NS on leaving CLR_B.
REQ-030 WALK SHALL exit after WALK_T to the green selected by next_dir.
REQ-031 ped_pending SHALL be set by ped_req=1 in any state other than WALK.
REQ-032 ped_pending SHALL be cleared on the edge entering WALK, and ped_ack SHALL be registered high for the first WALK cycle only.
REQ-033 ped_req asserted on the entering-WALK edge, or during WALK, SHALL be absorbed as already served.
REQ-034 tick=0 SHALL freeze all timing, while state and ped_pending updates remain edge-accurate.
REQ-035 Parameters SHALL satisfy 1 ≤ MIN_GREEN ≤ MAX_GREEN ≤ 255 and all other durations ≥ 1; an elaboration-time check SHALL enforce this.

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL enter CLR_B with the counter at 0, ped_pending=0, next_dir=NS and ped_ack=0.
REQ-037 Reset outputs SHALL be ns_red=1, ew_red=1 and all other lamps, walk and ped_ack 0.
REQ-038 Reset asserted mid-phase, including during WALK or green, SHALL abandon that phase immediately.
REQ-039 After reset, the first green SHALL be NS_GRN, reached after CLEAR_T ticks.

Structure
REQ-040 A package intersection_pkg SHALL hold the phase_t enum (3 bits) and the default duration constants.
REQ-041 One sub-module, phase_timer, SHALL hold the tick counter, with clear, tick and count ports plus a compare output for "expired at N".

Verification
REQ-042 The bench SHALL check: reset with tick every cycle, no cars and no ped → CLR_B 2, NS_GRN 20, NS_YEL 3, CLR_A 2, EW_GRN 20 cycles, with lamps per REQ-019.
REQ-043 The bench SHALL check: ew_car=1 held from cycle 2 of NS_GRN → NS_GRN lasts exactly 8 ticks.
REQ-044 The bench SHALL check: ped_req pulse during EW_GRN → EW_YEL, CLR_B, then WALK for 6 ticks with ped_ack on its first cycle, then NS_GRN.
REQ-045 The bench SHALL check: ped_req on the same edge that enters WALK → no second WALK follows.
REQ-046 The bench SHALL check: tick every 4th cycle → each phase spans 4×N cycles, with exits aligned to tick cycles.
REQ-047 The bench SHALL check: rst=1 for one cycle mid-WALK → next cycle shows both red, walk=0 and ped_pending=0, and the green-exclusivity assertion holds throughout.
